// File: rtl/sbox_inv_pkg.sv
// Shared constants and FSM encoding for the sequential inverse S-box.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   WIDTH   - symbol width of the 9-bit S-box
//   DEPTH   - number of table entries (2**WIDTH)
//   CNT_W   - build counter width (one extra bit so DEPTH-1 never aliases)
//   state_t - BUILD / READY / ERROR encoding
package sbox_inv_pkg;

    localparam int WIDTH = 9;
    localparam int DEPTH = 1 << WIDTH;
    localparam int CNT_W = WIDTH + 1;

    typedef enum logic [1:0] {
        BUILD = 2'd0,
        READY = 2'd1,
        ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/sbox9.sv
// 9-bit forward S-box: pure combinational permutation of the 9-bit space.
// Latency: 0 cycles (combinational).
// Backpressure: none (no handshake).
//
// Ports:
//   x - S-box input symbol
//   y - S-box output symbol
//
// Multiplication by an odd constant is invertible modulo 2**9, and adding a
// constant is too, so the mapping is a bijection.
module sbox9 (
    input  logic [8:0] x,
    output logic [8:0] y
);

    assign y = 9'(x * 9'd5) + 9'h1A3;

endmodule

// File: rtl/sbox_inv_ram.sv
// Inverse lookup table: DEPTH x W, one synchronous write port, one registered read port.
// Latency: 1 cycle from rd_en to rd_dat.
// Backpressure: none; rd_dat holds its value whenever rd_en is low.
//
// Ports:
//   clk, rst_n        - clock, async active-low reset (read register only)
//   wr_en/addr/dat    - write port, used during the table build
//   rd_en/addr        - read request, used for lookups
//   rd_dat            - registered read data, cleared by reset
module sbox_inv_ram #(
    parameter int W = 9,
    parameter int D = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [$clog2(D)-1:0] wr_addr,
    input  logic [W-1:0]         wr_dat,
    input  logic                 rd_en,
    input  logic [$clog2(D)-1:0] rd_addr,
    output logic [W-1:0]         rd_dat
);

    logic [W-1:0] mem [D];

    // Storage array carries no reset; every entry is rewritten by the build
    // sweep before any lookup is allowed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read register is reset so the visible result starts at zero, and it only
    // loads on a new read so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sbox9_inv_seq.sv
// Sequential inverse of sbox9: builds an inverse table after reset, then serves lookups.
// Latency: build takes DEPTH cycles; each lookup returns 1 cycle after acceptance.
// Backpressure: in_ready = !out_valid || out_ready while READY; a stalled result is held.
//
// Optional feature macro: SBOX_INV_SELFCHECK_EN (result self-check driving chk_err).
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/ready/data   - lookup request stream (in_data is an S-box output)
//   out_valid/ready/data  - result stream (out_data = x with sbox9(x) = in_data)
//   busy                  - table build in progress
//   err                   - sticky: the S-box produced a duplicate output
//   chk_err               - sticky: a returned result failed the forward re-check
module sbox9_inv_seq #(
    parameter int WIDTH = sbox_inv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err,
    output logic             chk_err
);

    import sbox_inv_pkg::*;

    localparam int DEPTH  = 1 << WIDTH;
    localparam int CNT_WD = WIDTH + 1;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_WD-1:0]   cnt_q;
    logic [DEPTH-1:0]    written_q;
    logic                err_q;
    logic                out_vld_q;

    logic [WIDTH-1:0]    sb_x;
    logic [WIDTH-1:0]    sb_y;
    logic                collide;
    logic                last_entry;
    logic                build_wr;
    logic                xfer;

    // Build sweep: the low bits of the counter are the S-box input; the
    // extra counter bit only matters for the end-of-sweep compare.
    assign sb_x       = cnt_q[WIDTH-1:0];
    assign collide    = written_q[sb_y];
    assign last_entry = (cnt_q == CNT_WD'(DEPTH - 1));
    assign build_wr   = (state_q == BUILD) && !collide;
    assign xfer       = in_valid && in_ready;

    sbox9 u_sbox_build (
        .x (sb_x),
        .y (sb_y)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUILD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUILD: begin
                if (collide) begin
                    state_d = ERROR;
                end else if (last_entry) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            BUILD: busy = 1'b1;
            READY: in_ready = !out_vld_q || out_ready;
            default: begin
                busy     = 1'b0;
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Build bookkeeping: counter, written bitmap, sticky bijection error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            written_q <= '0;
            err_q     <= 1'b0;
        end else if (state_q == BUILD) begin
            if (collide) begin
                err_q <= 1'b1;
            end else begin
                written_q[sb_y] <= 1'b1;
                cnt_q           <= cnt_q + CNT_WD'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result valid: set on a transfer, cleared when consumed without refill
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
        end else if (state_q != READY) begin
            out_vld_q <= 1'b0;
        end else if (xfer) begin
            out_vld_q <= 1'b1;
        end else if (out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    sbox_inv_ram #(
        .W (WIDTH),
        .D (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (build_wr),
        .wr_addr (sb_y),
        .wr_dat  (sb_x),
        .rd_en   (xfer),
        .rd_addr (in_data),
        .rd_dat  (out_data)
    );

    assign out_valid = out_vld_q;
    assign err       = err_q;

`ifdef SBOX_INV_SELFCHECK_EN
    // Re-run the forward S-box on each presented result and compare with the
    // request that produced it; a mismatch flags table corruption.
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] chk_y;
    logic             chk_err_q;

    sbox9 u_sbox_chk (
        .x (out_data),
        .y (chk_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (xfer) begin
                shadow_q <= in_data;
            end
            if (out_vld_q && (chk_y != shadow_q)) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sbox9_inv_seq.sv
// Scoreboard bench for sbox9_inv_seq: stimulus pushes expected inverses, a monitor pops on handshake.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready to exercise stalls.
module tb_sbox9_inv_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] out_data;
    logic       busy;
    logic       err;
    logic       chk_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    sbox9_inv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .err       (err),
        .chk_err   (chk_err)
    );

    // Hand-computed (S-box output, S-box input) pairs for sbox9(x) = 5x + 0x1A3 mod 512.
    logic [8:0] vec_y [5] = '{9'h1A3, 9'h1A8, 9'h19E, 9'h000, 9'h1FF};
    logic [8:0] vec_x [5] = '{9'h000, 9'h001, 9'h1FF, 9'h079, 9'h1AC};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: sample just before the rising edge and score every handshake.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected actual=%0h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", {23'd0, out_data}, {23'd0, e});
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called right after rst_n rises on a falling edge; counts edges until busy drops.
    task automatic wait_build(input string name);
        int n = 0;
        while (busy && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 512);
        check({name, "_rdy"}, in_ready, 1);
        check({name, "_err"}, err, 0);
        @(negedge clk);
    endtask

    // Called on a falling edge; offers one request for one cycle.
    task automatic send(input logic [8:0] y, input logic [8:0] x);
        in_valid = 1'b1;
        in_data  = y;
        #1;
        if (in_ready) exp_q.push_back(x);
        else check("send_accept", in_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int gaps;
        int p0;

        // ---------------- reset values ----------------
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 1);
        check("rst_err", err, 0);
        check("rst_chk_err", chk_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_build("build_cycles");

        // ---------------- directed vectors ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(vec_y[i], vec_x[i]);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("directed_drain", exp_q.size(), 0);

        // ---------------- full table, back-to-back ----------------
        acc  = 0;
        gaps = 0;
        p0   = n_pop;
        for (int x = 0; x < 512; x++) begin
            in_valid = 1'b1;
            in_data  = 9'(x * 5 + 419);
            #1;
            if (x > 0 && !out_valid) gaps++;
            if (in_ready) begin
                acc++;
                exp_q.push_back(9'(x));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("full_accepted", acc, 512);
        check("full_results", n_pop - p0, 512);
        check("full_no_gaps", gaps, 0);

        // ---------------- backpressure ----------------
        send(9'h1A8, 9'h001);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9'h000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_hold_data", out_data, 9'h001);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_accept", in_ready, 1);
        if (in_ready) exp_q.push_back(9'h079);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_drain", exp_q.size(), 0);

        // ---------------- reset while a result is in flight ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9'h19E;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_data", out_data, 9'h1FF);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready_out_valid", out_valid, 0);
        check("rst_ready_out_data", out_data, 0);
        check("rst_ready_busy", busy, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- reset mid-build at cnt=100 ----------------
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbuild_busy", busy, 1);
        check("midbuild_in_ready", in_ready, 0);
        check("midbuild_out_valid", out_valid, 0);
        check("midbuild_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_build("rebuild_cycles");
        out_ready = 1'b1;
        send(9'h19E, 9'h1FF);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rebuild_drain", exp_q.size(), 0);

        // ---------------- collision: S-box output stuck at zero ----------------
        @(negedge clk);
        rst_n = 1'b0;
        out_ready = 1'b0;
        force dut.sb_y = 9'h000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("coll_err_first", err, 0);
        @(posedge clk);
        #1;
        check("coll_err", err, 1);
        check("coll_busy", busy, 0);
        check("coll_in_ready", in_ready, 0);
        release dut.sb_y;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 9'h1A3;
        repeat (4) @(negedge clk);
        #1;
        check("coll_sticky_err", err, 1);
        check("coll_no_valid", out_valid, 0);
        check("coll_ready_low", in_ready, 0);
        check("coll_busy_low", busy, 0);
        in_valid = 1'b0;

        // ---------------- self-check ----------------
        do_reset();
        wait_build("chk_build_cycles");
`ifdef SBOX_INV_SELFCHECK_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9'h1A3;
        @(negedge clk);
        in_valid = 1'b0;
        force dut.u_ram.rd_dat = 9'h055;
        #1;
        check("selfchk_pre", chk_err, 0);
        @(posedge clk);
        #1;
        check("selfchk_flag", chk_err, 1);
        release dut.u_ram.rd_dat;
        do_reset();
        #1;
        check("selfchk_cleared", chk_err, 0);
`else
        out_ready = 1'b1;
        send(9'h1A3, 9'h000);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("selfchk_absent", chk_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox9_inv_seq.md
Name: sbox9_inv_seq

Overview:
- Sequential inverse of the 9-bit S-box (`sbox9`). Decodes ciphertext-side bytes back to S-box inputs.
- After reset, sweeps every input through an internal `sbox9` instance and writes the inverse lookup table. It also verifies the S-box is a bijection.
- Then serves inverse lookups over a valid/ready stream with 1-cycle latency.
- Sits beside `sbox9` in the datapath and in TestSuite, where it is checked against the same inputs.txt/outputs.txt vectors with the columns swapped.

Parameters:
- WIDTH, default 9 (equals `width`): symbol width.
- DEPTH, default 2**WIDTH: table entries; not overridable independently.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  block accepts a request this cycle.
- in_data  in  WIDTH  S-box output value to invert.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  inverse value x such that sbox9(x) = in_data.
- busy  out  1  table build in progress.
- err  out  1  sticky: the S-box is not bijective.
- chk_err  out  1  sticky self-check mismatch (optional feature).

Behaviour:
- Reset is asynchronous assert, synchronous deassert is handled outside this block. Reset values:
  - in_ready=0, out_valid=0, out_data=0, busy=1, err=0, chk_err=0.
  - State=BUILD, cnt=0, written-bitmap cleared.
- FSM states: BUILD, READY, ERROR.
- BUILD:
  - Each cycle: y = sbox9(cnt); write table[y] = cnt; set written[y]; cnt++.
  - If written[y] is already set, go to ERROR and set err=1.
  - When cnt = DEPTH-1 is written without collision, go to READY next cycle.
  - BUILD lasts exactly DEPTH (512) cycles; busy=1 throughout, in_ready=0.
- READY:
  - busy=0.
  - in_ready = !out_valid || out_ready.
  - Transfer happens when in_valid && in_ready. out_data <= table[in_data] and out_valid <= 1 on the next edge (latency 1).
  - If out_valid && out_ready && no new transfer, then out_valid <= 0.
  - Full throughput: one result per cycle while out_ready=1.
  - Backpressure: with out_valid=1 and out_ready=0, out_data is held stable and in_ready=0.
- ERROR:
  - Terminal until reset. busy=0, in_ready=0, out_valid=0, err=1.
- Reset mid-BUILD or mid-READY: everything aborts, the bitmap clears, and BUILD restarts from cnt=0. Any in-flight result is dropped.
- in_valid during BUILD or ERROR is ignored; no transfer occurs.
- cnt is WIDTH+1 bits wide, so there is no wrap-around ambiguity at DEPTH-1.

Optional Feature:
- Macro: SBOX_INV_SELFCHECK_EN.
- Defined:
  - A second `sbox9` instance recomputes sbox9(out_data) whenever out_valid=1.
  - The accepted in_data is held in a shadow register.
  - A mismatch sets chk_err=1, sticky until reset. Data flow is unaffected.
- Undefined: the second instance and shadow register are absent, and chk_err is tied to 0.

Decomposition:
- Package sbox_inv_pkg: WIDTH, DEPTH, and the state encoding (BUILD=2'd0, READY=2'd1, ERROR=2'd2).
- Sub-module sbox_inv_ram: DEPTH x WIDTH table with one synchronous write port and one synchronous read port. The read is registered, which provides the 1-cycle latency.
- The existing `sbox9` is reused unmodified for the build sweep and for the self-check.

Test Plan:
- Build timing: release rst_n at cycle 0 -> busy=1 for cycles 0..511; busy=0 and in_ready=1 at cycle 512; err=0.
- Full-table check: for every pair (x,y) from inputs.txt/outputs.txt, drive in_data=y back-to-back with out_ready=1 -> out_data=x one cycle later, 512 results in 512 cycles, no gaps.
- Backpressure: send y0, then hold out_ready=0 for 5 cycles -> out_data stays at the inverse of y0 and in_ready=0. Raise out_ready -> next request accepted the same cycle.
- Reset mid-build: assert rst_n=0 when cnt=100 -> outputs return to reset values immediately. After release, busy lasts a full 512 cycles again.
- Collision: force the internal sbox9 output to 9'h000 during BUILD -> err=1 after the cnt=1 write; state stays ERROR, in_ready=0, until reset.
- With SBOX_INV_SELFCHECK_EN: force a table entry corrupt, look it up -> chk_err=1 one cycle after out_valid. Without the macro, chk_err remains 0.
